// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage.
// Each clock performs one 33-bit add/subtract step. Multiply uses shift-add and
// divide uses restoring division. HI/LO are written only at the end of an
// operation, and done pulses for one cycle when they become valid.
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Operands latched on start. Raw a is kept for the divide-by-zero HI value.
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_raw, b_raw;

    // Iteration registers. addend holds the multiplicand or divisor magnitude.
    // shreg holds the multiplier (shifted out) or the dividend/quotient.
    // acc is the partial product high half or the running remainder.
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             res_neg, rem_neg, dz;

    logic is_div, is_signed, dz_now;
    logic [WIDTH:0]   mul_sum, rem_s, trial, acc_step;
    logic [WIDTH-1:0] shreg_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];
    assign dz_now    = is_div && (b_raw == '0);

    // Magnitude of a value when the operation is signed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    // Conditional two's-complement negate, single width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    // Conditional two's-complement negate, double width (full product).
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. Divide-by-zero skips the iterations and lets FIX write the trap result.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_PREP;
            S_PREP:  state_nxt = dz_now ? S_FIX : S_ITER;
            S_ITER:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_PREP, S_ITER, S_FIX: busy = 1'b1;
            S_DONE:                done = 1'b1;
            default: ;
        endcase
    end

    // One add/subtract step. Restoring divide keeps the shifted remainder when the trial goes negative.
    always_comb begin
        acc_step   = acc;
        shreg_step = shreg;
        mul_sum    = '0;
        rem_s      = '0;
        trial      = '0;
        if (!is_div) begin
            mul_sum    = shreg[0] ? (acc + {1'b0, addend}) : acc;
            acc_step   = {1'b0, mul_sum[WIDTH:1]};
            shreg_step = {mul_sum[0], shreg[WIDTH-1:1]};
        end else begin
            rem_s = {acc[WIDTH-1:0], shreg[WIDTH-1]};
            trial = rem_s - {1'b0, addend};
            if (!trial[WIDTH]) begin
                acc_step   = trial;
                shreg_step = {shreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_step   = rem_s;
                shreg_step = {shreg[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final sign correction and selection of the HI/LO values.
    always_comb begin
        prod = {acc[WIDTH-1:0], shreg};
        if (dz) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else if (!is_div) begin
            {fix_hi, fix_lo} = neg_2w(prod, is_signed && res_neg);
        end else begin
            fix_hi = neg_w(acc[WIDTH-1:0], is_signed && rem_neg);
            fix_lo = neg_w(shreg, is_signed && res_neg);
        end
    end

    // Operand latch and iteration datapath. These registers are always rewritten before use.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (start) begin
                op_q  <= op;
                a_raw <= a;
                b_raw <= b;
            end
            S_PREP: begin
                addend  <= is_div ? mag(b_raw, is_signed) : mag(a_raw, is_signed);
                shreg   <= is_div ? mag(a_raw, is_signed) : mag(b_raw, is_signed);
                acc     <= '0;
                res_neg <= a_raw[WIDTH-1] ^ b_raw[WIDTH-1];
                rem_neg <= a_raw[WIDTH-1];
                dz      <= dz_now;
            end
            S_ITER: begin
                acc   <= acc_step;
                shreg <= shreg_step;
            end
            default: ;
        endcase
    end

    // Architectural results and iteration counter. HI/LO change only in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) div_by_zero <= 1'b0;
                S_PREP: cnt <= '0;
                S_ITER: cnt <= cnt + CNT_W'(1);
                S_FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule
